spart_receiver: RTL and testbench

- Serial receive half of the SPART, the counterpart of the existing transmitter.
- Deserialises 8N1 asynchronous frames on rxd into a one-byte holding buffer and raises rda for the processor.
- Sampling is paced by the receive-enable pulse from the SPART baud downcounter, which fires OVERSAMPLE times per bit period.
- Instantiated in the spart top alongside the transmitter; the top drives rx_data onto databus during a read of ioaddr 2'b00.

---
 rtl/spart_receiver.sv | 151 +++++++++++++++
 tb/tb_spart_receiver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spart_receiver.sv
// spart_receiver: receive half of the SPART. It deserialises 8N1 frames on rxd,
// holds the last good byte and flags data-available, framing error and overrun.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   baud_r_enable one-clk tick, OVERSAMPLE per bit period
//   data_r_enable one-clk pulse when the processor reads the buffer
//   rxd           asynchronous serial input, idles high
//   rx_data       last correctly framed byte
//   rda           receive data available
//   framing_err   sticky, last frame had a zero stop bit
//   overrun       sticky, good frame arrived while rda was still set
module spart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_r_enable,
    input  logic                 data_r_enable,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 rxd_m_q, rxd_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            rxd_m_q   <= 1'b1;
            rxd_s_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            rxd_m_q   <= rxd;
            rxd_s_q   <= rxd_m_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        // A read clears the flags; frame completion below may override.
        rda_d     = rda_q & ~data_r_enable;
        fe_d      = fe_q & ~data_r_enable;
        ov_d      = ov_q & ~data_r_enable;

        if (baud_r_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d = '0;
                        bit_d  = '0;
                        // Line back high at mid start bit: false start.
                        state_d = rxd_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        // LSB first: new bit enters the MSB.
                        shift_d = DATA_BITS'({rxd_s_q, shift_q} >> 1);
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rxd_s_q) begin
                            rx_data_d = shift_q;
                            rda_d     = 1'b1;
                            if (rda_q && !data_r_enable) begin
                                ov_d = 1'b1;
                            end
                        end else begin
                            fe_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = fe_q;
    assign overrun     = ov_q;

endmodule

// File: tb/tb_spart_receiver.sv
// tb_spart_receiver: directed bench for spart_receiver.
// Baud tick every 4 clk, 64 clk per bit, frames driven phase-aligned to the tick.
module tb_spart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_r_enable;
    logic       data_r_enable;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int cyc;
    int checks;
    int errors;
    int rise;

    spart_receiver #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_r_enable(baud_r_enable),
        .data_r_enable(data_r_enable),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rda          (rda),
        .framing_err  (framing_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        baud_r_enable = (cyc % 4 == 0);
    endtask

    task automatic do_read();
        data_r_enable = 1'b1;
        step();
        data_r_enable = 1'b0;
    endtask

    // Cycle c of the frame is sampled at the (c+1)-th edge after start.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int rd_at, input int rst_at,
                              output int rise_at);
        logic [9:0] fr;
        fr      = {stop_b, d, 1'b0};
        rise_at = -1;
        while (cyc % 4 != 0) step();
        for (int c = 0; c < 640; c++) begin
            rxd           = fr[c / 64];
            data_r_enable = (c == rd_at);
            rst           = (c == rst_at);
            step();
            if (rda && rise_at < 0) rise_at = c + 1;
            if (c == rst_at) begin
                chk("midrst_rda", rda, 0);
                chk("midrst_data", rx_data, 0);
                chk("midrst_fe", framing_err, 0);
                chk("midrst_ov", overrun, 0);
            end
        end
        rxd           = 1'b1;
        data_r_enable = 1'b0;
        rst           = 1'b0;
    endtask

    initial begin
        cyc           = 0;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        rxd           = 1'b1;
        baud_r_enable = 1'b0;
        data_r_enable = 1'b0;
        repeat (3) step();
        chk("rst_data", rx_data, 0);
        chk("rst_rda", rda, 0);
        chk("rst_fe", framing_err, 0);
        chk("rst_ov", overrun, 0);
        rst = 1'b0;
        repeat (8) step();

        // Basic frame and latency from start edge.
        send_frame(8'hA5, 1'b1, -1, -1, rise);
        chk("a5_rise", rise, 613);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_rda", rda, 1);
        chk("a5_fe", framing_err, 0);
        chk("a5_ov", overrun, 0);
        do_read();
        chk("a5_rd_rda", rda, 0);
        chk("a5_rd_data", rx_data, 8'hA5);

        // 3-tick glitch is rejected.
        while (cyc % 4 != 0) step();
        rxd = 1'b0;
        repeat (12) step();
        rxd = 1'b1;
        repeat (60) step();
        chk("glitch_rda", rda, 0);
        chk("glitch_fe", framing_err, 0);
        send_frame(8'h3C, 1'b1, -1, -1, rise);
        chk("3c_data", rx_data, 8'h3C);
        chk("3c_rda", rda, 1);
        do_read();
        chk("3c_rd_rda", rda, 0);

        // Zero stop bit.
        send_frame(8'h5A, 1'b0, -1, -1, rise);
        chk("5a_fe", framing_err, 1);
        chk("5a_rda", rda, 0);
        chk("5a_data", rx_data, 8'h3C);
        repeat (64) step();
        chk("5a_idle_fe", framing_err, 1);
        chk("5a_idle_rda", rda, 0);
        do_read();
        chk("5a_rd_fe", framing_err, 0);

        // Back-to-back frames, no read in between.
        send_frame(8'h11, 1'b1, -1, -1, rise);
        send_frame(8'h22, 1'b1, -1, -1, rise);
        chk("b2b_data", rx_data, 8'h22);
        chk("b2b_rda", rda, 1);
        chk("b2b_ov", overrun, 1);
        chk("b2b_fe", framing_err, 0);
        do_read();
        chk("b2b_rd_rda", rda, 0);
        chk("b2b_rd_ov", overrun, 0);

        // Read on the completion clk of the second frame.
        send_frame(8'h66, 1'b1, -1, -1, rise);
        chk("66_rda", rda, 1);
        send_frame(8'h77, 1'b1, 612, -1, rise);
        chk("77_data", rx_data, 8'h77);
        chk("77_rda", rda, 1);
        chk("77_ov", overrun, 0);

        // Reset in bit 4; remaining bits are all ones.
        send_frame(8'hF0, 1'b1, -1, 340, rise);
        chk("f0_rda", rda, 0);
        chk("f0_data", rx_data, 0);
        repeat (20) step();
        send_frame(8'hC3, 1'b1, -1, -1, rise);
        chk("c3_data", rx_data, 8'hC3);
        chk("c3_rda", rda, 1);
        chk("c3_fe", framing_err, 0);
        chk("c3_ov", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
